// File: rtl/riscv_v_twos_comp_sel.sv
// Registered, lane-selectable two's-complement unit: blocks are grouped into elements by
// osize_vector/merge and each element is negated on request. Optional RISCV_V_TWOS_COMP_OVF_EN adds out_ovf.
module riscv_v_twos_comp_sel #(
  parameter int DATA_WIDTH  = 128,
  parameter int BLOCK_WIDTH = 8,
  parameter int NUM_OSIZES  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in,
  input  logic [DATA_WIDTH/BLOCK_WIDTH-1:0]   complement,
  input  logic [NUM_OSIZES-1:0]               osize_vector,
  input  logic [DATA_WIDTH/BLOCK_WIDTH-2:0]   merge,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out
`ifdef RISCV_V_TWOS_COMP_OVF_EN
  ,
  output logic [DATA_WIDTH/BLOCK_WIDTH-1:0]   out_ovf
`endif
);

  localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;

  // Interface: in_valid qualifies in/complement/osize_vector/merge on a rising edge; out_valid
  // marks out one cycle later. There is no ready: every valid input is accepted.

  int                    k;
  logic [NUM_BLOCKS-2:0] brk;
  logic [NUM_BLOCKS-1:0] first_blk;
  logic [NUM_BLOCKS-1:0] last_blk;

  // Lowest set osize bit wins; all-zero falls back to single-block elements.
  always_comb begin
    k = 0;
    for (int s = NUM_OSIZES - 1; s >= 0; s--) begin
      if (osize_vector[s]) k = s;
    end
    brk = '0;
    for (int i = 0; i < NUM_BLOCKS - 1; i++) begin
      brk[i] = (((i + 1) & ((1 << k) - 1)) == 0) && !merge[i];
    end
  end

  assign first_blk = {brk, 1'b1};
  assign last_blk  = {1'b1, brk};

  logic [DATA_WIDTH-1:0]  result;
  logic                   neg;
  logic                   carry;
  logic [BLOCK_WIDTH-1:0] blk;
  logic [BLOCK_WIDTH-1:0] opnd;
  logic [BLOCK_WIDTH:0]   sum;
`ifdef RISCV_V_TWOS_COMP_OVF_EN
  localparam int IDXW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [BLOCK_WIDTH-1:0] MOST_NEG = {1'b1, {(BLOCK_WIDTH-1){1'b0}}};
  logic [NUM_BLOCKS-1:0]  ovf;
  logic [IDXW-1:0]        start;
  logic                   low_zero;
`endif

  // The +1 is injected at each element's first block and the carry is cut at element ends.
  always_comb begin
    result = '0;
    neg    = 1'b0;
    carry  = 1'b0;
    blk    = '0;
    opnd   = '0;
    sum    = '0;
`ifdef RISCV_V_TWOS_COMP_OVF_EN
    ovf      = '0;
    start    = '0;
    low_zero = 1'b1;
`endif
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (first_blk[i]) begin
        neg   = complement[i];
        carry = complement[i];
`ifdef RISCV_V_TWOS_COMP_OVF_EN
        start    = IDXW'(i);
        low_zero = 1'b1;
`endif
      end
      blk   = in[i*BLOCK_WIDTH +: BLOCK_WIDTH];
      opnd  = neg ? ~blk : blk;
      sum   = {1'b0, opnd} + {{BLOCK_WIDTH{1'b0}}, carry};
      result[i*BLOCK_WIDTH +: BLOCK_WIDTH] = sum[BLOCK_WIDTH-1:0];
      carry = sum[BLOCK_WIDTH];
`ifdef RISCV_V_TWOS_COMP_OVF_EN
      // Most-negative element: top block is 100..0 and every lower block is zero.
      if (last_blk[i] && neg && low_zero && (blk == MOST_NEG)) ovf[start] = 1'b1;
      low_zero = low_zero && (blk == '0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
`ifdef RISCV_V_TWOS_COMP_OVF_EN
      out_ovf   <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= result;
`ifdef RISCV_V_TWOS_COMP_OVF_EN
        out_ovf <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_riscv_v_twos_comp_sel.sv
// Bench for riscv_v_twos_comp_sel at DATA_WIDTH=32, BLOCK_WIDTH=8; checks out_ovf when
// RISCV_V_TWOS_COMP_OVF_EN is defined.
module tb_riscv_v_twos_comp_sel;

  localparam int W  = 32;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in = '0;
  logic [NB-1:0] complement = '0;
  logic [3:0]    osize_vector = 4'b0001;
  logic [NB-2:0] merge = '0;
  logic          out_valid;
  logic [W-1:0]  out;
`ifdef RISCV_V_TWOS_COMP_OVF_EN
  logic [NB-1:0] out_ovf;
`endif

  riscv_v_twos_comp_sel #(.DATA_WIDTH(W), .BLOCK_WIDTH(8), .NUM_OSIZES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .complement(complement),
    .osize_vector(osize_vector), .merge(merge), .out_valid(out_valid), .out(out)
`ifdef RISCV_V_TWOS_COMP_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic          armed = 1'b0;
  logic          vld_exp = 1'b0;
  logic [W-1:0]  last_exp = '0;
  logic [W-1:0]  exp_q[$];
  logic [NB-1:0] exp_ovf_q[$];

  // Reference: walk elements, negate each as one wide integer.
  function automatic logic [W-1:0] model(input logic [W-1:0] din, input logic [NB-1:0] comp,
                                         input logic [3:0] os, input logic [NB-2:0] mg,
                                         output logic [NB-1:0] ovf);
    logic [W-1:0] res;
    logic [63:0]  v, mask;
    int kk, esz, j, e, w;
    kk = 0;
    for (int s = 3; s >= 0; s--) if (os[s]) kk = s;
    esz = 1 << kk;
    res = '0;
    ovf = '0;
    j = 0;
    while (j < NB) begin
      e = j;
      while (e < NB - 1 && !((((e + 1) % esz) == 0) && !mg[e])) e++;
      w = (e - j + 1) * 8;
      mask = (64'd1 << w) - 64'd1;
      v = ({32'd0, din} >> (j * 8)) & mask;
      if (comp[j]) begin
        if (v == (64'd1 << (w - 1))) ovf[j] = 1'b1;
        v = (~v + 64'd1) & mask;
      end
      res = res | W'(v << (j * 8));
      j = e + 1;
    end
    return res;
  endfunction

  always @(posedge clk) vld_exp <= rst ? 1'b0 : in_valid;

  // Scoreboard: pop one expectation for every output the DUT marks valid.
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (out_valid !== vld_exp) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, vld_exp, $time);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h with empty queue at %0t", out, $time);
        end else begin
          last_exp = exp_q.pop_front();
          if (out !== last_exp) begin
            errors++;
            $display("FAIL out_data: got %h expected %h at %0t", out, last_exp, $time);
          end
`ifdef RISCV_V_TWOS_COMP_OVF_EN
          begin
            logic [NB-1:0] eo;
            eo = exp_ovf_q.pop_front();
            checks++;
            if (out_ovf !== eo) begin
              errors++;
              $display("FAIL out_ovf: got %b expected %b at %0t", out_ovf, eo, $time);
            end
          end
`else
          void'(exp_ovf_q.pop_front());
`endif
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [NB-1:0] c, input logic [3:0] os,
                      input logic [NB-2:0] mg, input logic [W-1:0] e_out, input logic [NB-1:0] e_ovf);
    @(negedge clk);
    in_valid = 1'b1; in = d; complement = c; osize_vector = os; merge = mg;
    exp_q.push_back(e_out);
    exp_ovf_q.push_back(e_ovf);
  endtask

  task automatic send_model(input logic [W-1:0] d, input logic [NB-1:0] c, input logic [3:0] os,
                            input logic [NB-2:0] mg);
    logic [W-1:0]  e;
    logic [NB-1:0] o;
    e = model(d, c, os, mg, o);
    send(d, c, os, mg, e, o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in = 32'hDEADBEEF; complement = 4'hF;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", out); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    rst = 1'b0; in_valid = 1'b0;
    armed = 1'b1;
  endtask

  typedef struct packed {
    logic [W-1:0]  d;
    logic [NB-1:0] c;
    logic [3:0]    os;
    logic [NB-2:0] mg;
    logic [W-1:0]  e;
    logic [NB-1:0] o;
  } vec_t;

  task automatic test_directed;
    vec_t tbl[9];
    tbl[0] = '{32'h00000001, 4'b0001, 4'b0001, 3'b000, 32'h000000FF, 4'b0000};
    tbl[1] = '{32'h00010001, 4'b0101, 4'b0010, 3'b000, 32'hFFFFFFFF, 4'b0000};
    tbl[2] = '{32'h00010001, 4'b0100, 4'b0010, 3'b000, 32'hFFFF0001, 4'b0000};
    tbl[3] = '{32'h00000001, 4'b1110, 4'b0100, 3'b000, 32'h00000001, 4'b0000};
    tbl[4] = '{32'h00000001, 4'b0001, 4'b0100, 3'b000, 32'hFFFFFFFF, 4'b0000};
    tbl[5] = '{32'h00000001, 4'b0001, 4'b0001, 3'b001, 32'h0000FFFF, 4'b0000};
    tbl[6] = '{32'h80000000, 4'b1111, 4'b0001, 3'b000, 32'h80000000, 4'b1000};
    tbl[7] = '{32'h00000000, 4'b1111, 4'b0001, 3'b000, 32'h00000000, 4'b0000};
    tbl[8] = '{32'h00000001, 4'b0001, 4'b0000, 3'b000, 32'h000000FF, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].d, tbl[i].c, tbl[i].os, tbl[i].mg, tbl[i].e, tbl[i].o);
      idle(1);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d;
      d = $urandom();
      if ($urandom_range(0, 3) == 0) d = 32'h80000000 >> (8 * $urandom_range(0, 3));
      send_model(d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end
    idle(2);
  endtask

  task automatic test_hold;
    send_model(32'h12345678, 4'b1111, 4'b0001, 3'b000);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out !== last_exp) begin
        errors++;
        $display("FAIL hold_out: got %h expected %h", out, last_exp);
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_reset_mid;
    send_model(32'hA5A5A5A5, 4'b0011, 4'b0001, 3'b000);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in = 32'h11111111;
    @(negedge clk);
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_mid_out: got %h expected 0", out); end
    rst = 1'b0; in_valid = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
